mac_array: RTL and testbench

- Matrix-multiply engine: computes OUT = IN(T×N) × W(N×M), with M, N, T each in 1..8.
- Reads 8-bit signed elements from two external read-only SRAMs: input rows, and weight rows stored transposed.
- Writes 16-bit results into a 16-entry output SRAM, two words per output row.
- Sits between a host that supplies START/MNT and three synchronous single-port SRAMs.

---
 rtl/mac_array.sv | 208 ++++++++++++++++++++
 tb/tb_mac_array.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array.sv
// mac_array: 8x8 signed matrix-multiply engine, OUT = IN(TxN) x W(NxM).
// Weight rows are preloaded from a read-only SRAM into a register file.
// Each input row is then read, multiplied against all weight rows in
// parallel, and written out as two 64-bit words (four 16-bit lanes each).
module mac_array (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic [11:0] MNT,
  output logic        EN_W,
  output logic [2:0]  ADDR_W,
  input  logic [63:0] RDATA_W,
  output logic        EN_I,
  output logic [2:0]  ADDR_I,
  input  logic [63:0] RDATA_I,
  output logic        EN_O,
  output logic        RW_O,
  output logic [3:0]  ADDR_O,
  output logic [63:0] WDATA_O,
  input  logic [63:0] RDATA_O
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADW = 3'd1,
    RDI   = 3'd2,
    CAP   = 3'd3,
    WR0   = 3'd4,
    WR1   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state;
  logic [3:0]  m_dim;      // latched, clamped M (1..8)
  logic [3:0]  n_dim;      // latched, clamped N (1..8)
  logic [3:0]  t_dim;      // latched, clamped T (1..8)
  logic [3:0]  lw_cnt;     // edges elapsed in LOADW
  logic [2:0]  row;        // current output row t
  logic [63:0] w_rf [8];   // weight row m (already N-masked)
  logic [63:0] in_row;     // current input row (already N/T-masked)

  logic [63:0]  n_mask;    // 0xFF in byte n when n < N
  logic [63:0]  in_next;   // masked input row as it arrives from SRAM
  logic [63:0]  src_row;   // row feeding the multipliers this cycle
  logic [127:0] res_flat;  // result(m) at [16m +: 16]
  logic [63:0]  word_lo;   // lanes for m = 0..3
  logic [63:0]  word_hi;   // lanes for m = 4..7

  // Read data of the output SRAM is never needed
  logic unused_rdata;
  assign unused_rdata = ^RDATA_O;

  // Out-of-range dimension fields are clamped into 1..8
  function automatic logic [3:0] clamp_dim(input logic [3:0] v);
    if (v == 4'd0)
      clamp_dim = 4'd1;
    else if (v > 4'd8)
      clamp_dim = 4'd8;
    else
      clamp_dim = v;
  endfunction

  genvar gi;

  // Byte mask selecting the first N elements of a row
  for (gi = 0; gi < 8; gi++) begin : g_nmask
    assign n_mask[63-8*gi -: 8] = (4'(gi) < n_dim) ? 8'hFF : 8'h00;
  end

  // Rows past T are treated as all-zero without trusting SRAM content
  assign in_next = ({1'b0, row} < t_dim) ? (RDATA_I & n_mask) : 64'd0;

  // In CAP the row is still on the SRAM bus; afterwards it is registered
  assign src_row = (state == CAP) ? in_next : in_row;

  // One dot product per weight row, accumulated in 19 bits
  for (gi = 0; gi < 8; gi++) begin : g_mac
    logic [18:0] acc;
    logic [15:0] sum_lo;
    logic [2:0]  unused_hi;

    // Sign-extended 8x8 products summed over all eight elements
    always_comb begin : mac_sum
      logic [15:0] a16;
      logic [15:0] b16;
      logic [15:0] p16;
      acc = 19'd0;
      a16 = 16'd0;
      b16 = 16'd0;
      p16 = 16'd0;
      for (int n = 0; n < 8; n++) begin
        a16 = {{8{src_row[63-8*n]}}, src_row[63-8*n -: 8]};
        b16 = {{8{w_rf[gi][63-8*n]}}, w_rf[gi][63-8*n -: 8]};
        p16 = a16 * b16;
        acc = acc + {{3{p16[15]}}, p16};
      end
    end

    assign {unused_hi, sum_lo} = acc;
    assign res_flat[16*gi +: 16] = sum_lo;
  end

  // Lane j of each output word holds result for m = j (low) or m = 4+j (high)
  for (gi = 0; gi < 4; gi++) begin : g_pack
    assign word_lo[63-16*gi -: 16] = res_flat[16*gi +: 16];
    assign word_hi[63-16*gi -: 16] = res_flat[16*(gi+4) +: 16];
  end

  // Control FSM; all SRAM-facing outputs are registered and default to idle
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      m_dim   <= 4'd1;
      n_dim   <= 4'd1;
      t_dim   <= 4'd1;
      lw_cnt  <= 4'd0;
      row     <= 3'd0;
      in_row  <= 64'd0;
      for (int i = 0; i < 8; i++) w_rf[i] <= 64'd0;
      EN_W    <= 1'b0;
      ADDR_W  <= 3'd0;
      EN_I    <= 1'b0;
      ADDR_I  <= 3'd0;
      EN_O    <= 1'b0;
      RW_O    <= 1'b0;
      ADDR_O  <= 4'd0;
      WDATA_O <= 64'd0;
    end else begin
      EN_W    <= 1'b0;
      ADDR_W  <= 3'd0;
      EN_I    <= 1'b0;
      ADDR_I  <= 3'd0;
      EN_O    <= 1'b0;
      RW_O    <= 1'b0;
      ADDR_O  <= 4'd0;
      WDATA_O <= 64'd0;
      case (state)
        IDLE: begin
          if (START) begin
            m_dim  <= clamp_dim(MNT[11:8]);
            n_dim  <= clamp_dim(MNT[7:4]);
            t_dim  <= clamp_dim(MNT[3:0]);
            for (int i = 0; i < 8; i++) w_rf[i] <= 64'd0;
            lw_cnt <= 4'd0;
            EN_W   <= 1'b1;
            ADDR_W <= 3'd0;
            state  <= LOADW;
          end
        end
        LOADW: begin
          // Read m issued at LOADW entry + m, captured two edges later
          lw_cnt <= lw_cnt + 4'd1;
          if ((lw_cnt + 4'd1) < m_dim) begin
            EN_W   <= 1'b1;
            ADDR_W <= 3'(lw_cnt + 4'd1);
          end
          if (lw_cnt != 4'd0)
            w_rf[3'(lw_cnt - 4'd1)] <= RDATA_W & n_mask;
          if (lw_cnt == m_dim) begin
            row    <= 3'd0;
            EN_I   <= 1'b1;
            ADDR_I <= 3'd0;
            state  <= RDI;
          end
        end
        RDI: begin
          state <= CAP;
        end
        CAP: begin
          in_row  <= in_next;
          EN_O    <= 1'b1;
          RW_O    <= 1'b1;
          ADDR_O  <= {row, 1'b0};
          WDATA_O <= word_lo;
          state   <= WR0;
        end
        WR0: begin
          EN_O    <= 1'b1;
          RW_O    <= 1'b1;
          ADDR_O  <= {row, 1'b1};
          WDATA_O <= word_hi;
          state   <= WR1;
        end
        WR1: begin
          if (row == 3'd7) begin
            state <= DONE;
          end else begin
            row <= row + 3'd1;
            if (({1'b0, row} + 4'd1) < t_dim) begin
              EN_I   <= 1'b1;
              ADDR_I <= row + 3'd1;
            end
            state <= RDI;
          end
        end
        DONE: begin
          // Wait for START to drop so a held request runs only once
          if (!START)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: directed and random checks of mac_array against a
// plain-arithmetic matrix-multiply model, with behavioural SRAMs.
module tb_mac_array;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START;
  logic [11:0] MNT;
  logic        EN_W;
  logic [2:0]  ADDR_W;
  logic [63:0] RDATA_W = 64'd0;
  logic        EN_I;
  logic [2:0]  ADDR_I;
  logic [63:0] RDATA_I = 64'd0;
  logic        EN_O;
  logic        RW_O;
  logic [3:0]  ADDR_O;
  logic [63:0] WDATA_O;
  logic [63:0] RDATA_O = 64'd0;

  mac_array dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .MNT(MNT),
    .EN_W(EN_W), .ADDR_W(ADDR_W), .RDATA_W(RDATA_W),
    .EN_I(EN_I), .ADDR_I(ADDR_I), .RDATA_I(RDATA_I),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
    .RDATA_O(RDATA_O)
  );

  always #5 CLK = ~CLK;

  logic [63:0] wmem [8];
  logic [63:0] imem [8];
  logic [63:0] omem [16];
  int writes = 0;
  int viol = 0;
  int cyc = 0;
  int first_enw = -1;
  int last_wr = -1;
  int exp_m = 8;
  int exp_t = 8;
  int nassert = 0;
  int nfail = 0;

  // SRAM models plus protocol monitor; unselected SRAMs return garbage
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (EN_W) RDATA_W <= wmem[ADDR_W];
    else      RDATA_W <= {$urandom, $urandom};
    if (EN_I) RDATA_I <= imem[ADDR_I];
    else      RDATA_I <= {$urandom, $urandom};
    if (EN_O && RW_O) begin
      omem[ADDR_O] <= WDATA_O;
      writes       <= writes + 1;
      last_wr      <= cyc;
    end
    if (EN_W && first_enw < 0) first_enw <= cyc;
    if ((EN_W && int'(ADDR_W) >= exp_m) || (EN_I && int'(ADDR_I) >= exp_t) ||
        (int'(EN_W) + int'(EN_I) + int'(EN_O) > 1) || (RW_O && !EN_O))
      viol <= viol + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v == 0) return 1;
    if (v > 8) return 8;
    return v;
  endfunction

  // Expected output word: OUT[t][m] = sum_n IN[t][n]*W[m][n], low 16 bits
  function automatic logic [63:0] ref_word(input int a, input int em, input int en, input int et);
    logic [63:0] word;
    logic signed [7:0] x;
    logic signed [7:0] y;
    int t;
    int m;
    int s;
    word = 64'd0;
    t = a / 2;
    for (int j = 0; j < 4; j++) begin
      m = (a % 2) * 4 + j;
      s = 0;
      if (t < et && m < em)
        for (int n = 0; n < en; n++) begin
          x = imem[t][63-8*n -: 8];
          y = wmem[m][63-8*n -: 8];
          s = s + int'(x) * int'(y);
        end
      word[63-16*j -: 16] = s[15:0];
    end
    return word;
  endfunction

  task automatic prep(input logic [11:0] mnt);
    exp_m = clampv(int'(mnt[11:8]));
    exp_t = clampv(int'(mnt[3:0]));
    for (int i = 0; i < 16; i++) omem[i] = 64'hA5A5_A5A5_A5A5_A5A5;
    writes = 0;
    viol = 0;
    first_enw = -1;
    last_wr = -1;
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 300 && writes < n; k++) @(negedge CLK);
  endtask

  task automatic check_run(input string tag, input logic [11:0] mnt);
    int em;
    int en;
    int et;
    em = clampv(int'(mnt[11:8]));
    en = clampv(int'(mnt[7:4]));
    et = clampv(int'(mnt[3:0]));
    chk({tag, " writes"}, 64'(writes), 64'd16);
    chk({tag, " protocol"}, 64'(viol), 64'd0);
    chk({tag, " length"}, 64'(last_wr - first_enw + 1), 64'(em + 33));
    for (int a = 0; a < 16; a++)
      chk($sformatf("%s omem[%0d]", tag, a), omem[a], ref_word(a, em, en, et));
    $display("run %s MNT=%h writes=%0d length=%0d", tag, mnt, writes, last_wr - first_enw + 1);
  endtask

  // Complete run with START held; optionally perturb MNT mid-run
  task automatic run_job(input string tag, input logic [11:0] mnt, input bit scramble);
    @(negedge CLK);
    prep(mnt);
    MNT = mnt;
    START = 1'b1;
    if (scramble) begin
      repeat (3) @(negedge CLK);
      MNT = 12'($urandom);
    end
    wait_writes(16);
    repeat (10) @(negedge CLK);
    check_run(tag, mnt);
    START = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " ctl"}, 64'({EN_W, ADDR_W, EN_I, ADDR_I, EN_O, RW_O, ADDR_O}), 64'd0);
    chk({tag, " wdata"}, WDATA_O, 64'd0);
  endtask

  task automatic fill_random;
    for (int i = 0; i < 8; i++) begin
      wmem[i] = {$urandom, $urandom};
      imem[i] = {$urandom, $urandom};
    end
  endtask

  logic [11:0] rmnt;

  initial begin
    RSTN = 1'b0;
    START = 1'b0;
    MNT = 12'h000;
    for (int i = 0; i < 8; i++) begin
      wmem[i] = 64'd0;
      imem[i] = 64'd0;
    end
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle_outputs("post_reset_idle");

    // 4x4x4 identity-like pattern
    for (int i = 0; i < 8; i++) begin
      imem[i] = (i < 4) ? 64'h0102_0304_0000_0000 : 64'd0;
      wmem[i] = (i < 4) ? 64'h0100_0000_0000_0000 : 64'd0;
    end
    run_job("m444", 12'h444, 1'b0);
    chk("m444 addr0", omem[0], 64'h0001_0001_0001_0001);

    // All ones, full size
    for (int i = 0; i < 8; i++) begin
      imem[i] = 64'h0101_0101_0101_0101;
      wmem[i] = 64'h0101_0101_0101_0101;
    end
    run_job("m888_ones", 12'h888, 1'b0);
    chk("m888 addr15", omem[15], 64'h0008_0008_0008_0008);

    // 1x1x1 with garbage everywhere outside the active element
    fill_random();
    imem[0][63:56] = 8'hFF;
    wmem[0][63:56] = 8'h80;
    run_job("m111", 12'h111, 1'b0);
    chk("m111 addr0", omem[0], 64'h0080_0000_0000_0000);

    // Accumulator wrap: 8 * 16384 = 0x20000
    for (int i = 0; i < 8; i++) begin
      imem[i] = 64'h8080_8080_8080_8080;
      wmem[i] = 64'h8080_8080_8080_8080;
    end
    run_job("overflow", 12'h888, 1'b0);
    chk("overflow addr6", omem[6], 64'd0);

    // Random sizes (including out-of-range fields) and data
    for (int r = 0; r < 8; r++) begin
      fill_random();
      rmnt = 12'($urandom);
      run_job($sformatf("rand%0d", r), rmnt, r[0]);
    end

    // START held for 1000 cycles runs only once, then reruns after a drop
    fill_random();
    @(negedge CLK);
    prep(12'h736);
    MNT = 12'h736;
    START = 1'b1;
    repeat (1000) @(negedge CLK);
    check_run("hold1", 12'h736);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    prep(12'h736);
    START = 1'b1;
    wait_writes(16);
    repeat (10) @(negedge CLK);
    check_run("hold2", 12'h736);
    START = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset during LOADW, then a fresh run with START still high
    fill_random();
    @(negedge CLK);
    prep(12'h858);
    MNT = 12'h858;
    START = 1'b1;
    repeat (3) @(negedge CLK);
    chk("loadw_active", 64'(EN_W), 64'd1);
    RSTN = 1'b0;
    #1;
    check_idle_outputs("rst_loadw");
    @(negedge CLK);
    prep(12'h858);
    RSTN = 1'b1;
    wait_writes(16);
    repeat (10) @(negedge CLK);
    check_run("after_rst_loadw", 12'h858);
    START = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset in the middle of the row phase
    fill_random();
    @(negedge CLK);
    prep(12'h387);
    MNT = 12'h387;
    START = 1'b1;
    wait_writes(5);
    RSTN = 1'b0;
    #1;
    check_idle_outputs("rst_row");
    repeat (2) @(negedge CLK);
    prep(12'h387);
    RSTN = 1'b1;
    wait_writes(16);
    repeat (10) @(negedge CLK);
    check_run("after_rst_row", 12'h387);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
